// File: rtl/clk_div_nmode_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : clk_div_nmode_pkg
//  Description : Shared constants for the multi-mode clock divider: default
//                50 MHz half-period table (1/2/5/10 Hz), default mode
//                encodings and the default parameter set.
//  Revision    : 1.0 - initial release
// ============================================================================
package clk_div_nmode_pkg;

  // Reference system clock for the default half-period table.
  localparam int unsigned CLK_HZ = 50_000_000;

  // Default parameter set: four rates, 2-bit select, 26-bit counter.
  localparam int DEF_NUM_MODES = 4;
  localparam int DEF_SEL_W     = 2;
  localparam int DEF_CNT_W     = 26;

  // Number of clk cycles in one half period of a square wave at out_hz.
  function automatic int unsigned hz_to_half(input int unsigned clk_hz,
                                             input int unsigned out_hz);
    return clk_hz / (2 * out_hz);
  endfunction

  // Half periods at 50 MHz for the default rates.
  localparam logic [DEF_CNT_W-1:0] HALF_10HZ = DEF_CNT_W'(hz_to_half(CLK_HZ, 10));
  localparam logic [DEF_CNT_W-1:0] HALF_5HZ  = DEF_CNT_W'(hz_to_half(CLK_HZ, 5));
  localparam logic [DEF_CNT_W-1:0] HALF_2HZ  = DEF_CNT_W'(hz_to_half(CLK_HZ, 2));
  localparam logic [DEF_CNT_W-1:0] HALF_1HZ  = DEF_CNT_W'(hz_to_half(CLK_HZ, 1));

  // Default mode encodings; mode i sits at bits [i*CNT_W +: CNT_W].
  typedef enum logic [DEF_SEL_W-1:0] {
    MODE_10HZ = 2'd0,
    MODE_5HZ  = 2'd1,
    MODE_2HZ  = 2'd2,
    MODE_1HZ  = 2'd3
  } rate_mode_e;

  // Packed default table: mode0 (fastest) in the least significant slot.
  localparam logic [DEF_NUM_MODES*DEF_CNT_W-1:0] DEF_HALF_PERIODS =
    {HALF_1HZ, HALF_2HZ, HALF_5HZ, HALF_10HZ};

endpackage
`default_nettype wire

// File: rtl/clk_div_nmode_sync2.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : sync2
//  Description : Parametrised-width two-flop synchroniser with asynchronous
//                active-low reset. Used for the asynchronous mode select.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // First flop may go metastable; second flop gives it a full cycle to settle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/clk_div_nmode.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : clk_div_nmode
//  Description : Multi-mode glitch-free clock divider. Produces a 50% duty
//                square wave y whose half period is selected from a packed
//                table; a 1-cycle tick marks each rising edge of y. Mode
//                changes are deferred to the end of a high phase (or applied
//                at once while the divider is disabled), so y never carries
//                a truncated pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_div_nmode
  import clk_div_nmode_pkg::*;
#(
  parameter int                          NUM_MODES    = DEF_NUM_MODES,
  parameter int                          SEL_W        = DEF_SEL_W,
  parameter int                          CNT_W        = DEF_CNT_W,
  parameter logic [NUM_MODES*CNT_W-1:0]  HALF_PERIODS = DEF_HALF_PERIODS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [SEL_W-1:0] sel,
  output logic             y,
  output logic             tick,
  output logic [SEL_W-1:0] mode,
  output logic             switching
);

  // Mode count widened by one bit so the range check also works when
  // NUM_MODES == 2**SEL_W.
  localparam logic [SEL_W:0]   NUM_MODES_W = (SEL_W+1)'(NUM_MODES);
  localparam logic [SEL_W-1:0] MODE_RST    = SEL_W'(MODE_10HZ);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic             y_q,         y_d;
  logic             tick_q,      tick_d;
  logic [SEL_W-1:0] mode_q,      mode_d;
  logic             switching_q, switching_d;

  // --------------------------------------------------------------------------
  // Select synchronisation and qualification
  // --------------------------------------------------------------------------
  logic [SEL_W-1:0] sel_s;
  logic             sel_valid;

  sync2 #(
    .WIDTH (SEL_W)
  ) u_sel_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (sel),
    .q_o   (sel_s)
  );

  assign sel_valid = ({1'b0, sel_s} < NUM_MODES_W);

  // --------------------------------------------------------------------------
  // Half-period lookup for the applied mode
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] half_raw;
  logic [CNT_W-1:0] half_eff;

  // Mux the applied mode's half period out of the packed table; zero means one.
  always_comb begin
    half_raw = '0;
    for (int i = 0; i < NUM_MODES; i++) begin
      if (mode_q == SEL_W'(i)) begin
        half_raw = HALF_PERIODS[i*CNT_W +: CNT_W];
      end
    end
    half_eff = (half_raw == '0) ? CNT_W'(1) : half_raw;
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  logic phase_end;
  logic apply_switch;

  assign phase_end = (cnt_q == (half_eff - CNT_W'(1)));

  // A pending change lands only while y is (or is about to be) low: at the
  // end of a high phase, or on any edge where the divider is disabled.
  assign apply_switch = switching_q && sel_valid &&
                        (!en || (phase_end && y_q));

  // Counter, output wave, tick and mode/pending updates for the coming edge.
  always_comb begin
    cnt_d       = cnt_q;
    y_d         = y_q;
    tick_d      = 1'b0;
    mode_d      = mode_q;
    switching_d = sel_valid && (sel_s != mode_q);

    if (!en) begin
      cnt_d = '0;
      y_d   = 1'b0;
    end else if (phase_end) begin
      cnt_d  = '0;
      y_d    = ~y_q;
      tick_d = ~y_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (apply_switch) begin
      mode_d      = sel_s;
      switching_d = 1'b0;
    end
  end

  // Register all divider state; reset forces every output low immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q       <= '0;
      y_q         <= 1'b0;
      tick_q      <= 1'b0;
      mode_q      <= MODE_RST;
      switching_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      y_q         <= y_d;
      tick_q      <= tick_d;
      mode_q      <= mode_d;
      switching_q <= switching_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign y         = y_q;
  assign tick      = tick_q;
  assign mode      = mode_q;
  assign switching = switching_q;

endmodule
`default_nettype wire

// File: tb/tb_clk_div_nmode.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_clk_div_nmode
//  Description : Self-checking bench for clk_div_nmode with a 4-bit counter
//                and half periods 8/4/2/1 (plus a 3-mode instance).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_div_nmode;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [1:0] sel;

  logic       y4, tick4, sw4;
  logic [1:0] mode4;
  logic       y3, tick3, sw3;
  logic [1:0] mode3;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  clk_div_nmode #(
    .NUM_MODES    (4),
    .SEL_W        (2),
    .CNT_W        (4),
    .HALF_PERIODS ({4'd1, 4'd2, 4'd4, 4'd8})
  ) dut4 (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .sel       (sel),
    .y         (y4),
    .tick      (tick4),
    .mode      (mode4),
    .switching (sw4)
  );

  clk_div_nmode #(
    .NUM_MODES    (3),
    .SEL_W        (2),
    .CNT_W        (4),
    .HALF_PERIODS ({4'd2, 4'd4, 4'd8})
  ) dut3 (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .sel       (sel),
    .y         (y3),
    .tick      (tick3),
    .mode      (mode3),
    .switching (sw3)
  );

  // --------------------------------------------------------------------------
  // Reference model (4-mode instance), phase based: a phase starts at some
  // edge and lasts H edges of the mode in force when it began.
  // --------------------------------------------------------------------------
  int hp[4] = '{8, 4, 2, 1};
  int m_k, m_ps, m_mode, m_s1, m_ss;
  bit m_y, m_tick, m_sw;

  task automatic model_reset();
    m_k = 0; m_ps = 0; m_mode = 0; m_s1 = 0; m_ss = 0;
    m_y = 0; m_tick = 0; m_sw = 0;
  endtask

  task automatic model_edge();
    int  ss_old, h;
    bit  valid, apply;
    if (reset !== 1'b1) return;
    m_k++;
    ss_old = m_ss;
    m_ss   = m_s1;
    m_s1   = int'(sel);
    valid  = (ss_old < 4);
    h      = (hp[m_mode] == 0) ? 1 : hp[m_mode];
    apply  = 0;
    m_tick = 0;
    if (!en) begin
      m_y   = 0;
      m_ps  = m_k;
      apply = m_sw && valid;
    end else if (m_k - m_ps == h) begin
      m_ps   = m_k;
      m_tick = !m_y;
      apply  = m_y && m_sw && valid;
      m_y    = !m_y;
    end
    if (apply) begin
      m_mode = ss_old;
      m_sw   = 0;
    end else begin
      m_sw = valid && (ss_old != m_mode);
    end
  endtask

  // One clock edge; outputs are sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Hold reset for three edges with the given select, then release so the
  // next rising edge is edge 1.
  task automatic start(input logic [1:0] s);
    reset = 1'b0;
    en    = 1'b1;
    sel   = s;
    model_reset();
    for (int i = 0; i < 3; i++) step();
    reset = 1'b1;
  endtask

  // --------------------------------------------------------------------------
  // Scenarios
  // --------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b0; en = 1'b1; sel = 2'd2;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++; if (y4 !== 1'b0)     begin n_err++; $display("FAIL reset_y cyc=%0d got %b want 0", i, y4); end
      n_cmp++; if (tick4 !== 1'b0)  begin n_err++; $display("FAIL reset_tick cyc=%0d got %b want 0", i, tick4); end
      n_cmp++; if (mode4 !== 2'd0)  begin n_err++; $display("FAIL reset_mode cyc=%0d got %0d want 0", i, mode4); end
      n_cmp++; if (sw4 !== 1'b0)    begin n_err++; $display("FAIL reset_switching cyc=%0d got %b want 0", i, sw4); end
    end
  endtask

  task automatic test_basic();
    start(2'd0);
    for (int e = 1; e <= 32; e++) begin
      step();
      n_cmp++; if (y4 !== 1'((e / 8) % 2)) begin n_err++; $display("FAIL basic_y edge=%0d got %b want %b", e, y4, 1'((e / 8) % 2)); end
      n_cmp++; if (tick4 !== 1'(e % 16 == 8)) begin n_err++; $display("FAIL basic_tick edge=%0d got %b want %b", e, tick4, 1'(e % 16 == 8)); end
    end
  endtask

  task automatic test_switch();
    start(2'd0);
    for (int e = 1; e <= 24; e++) begin
      step();
      if (e == 3) sel = 2'd3;
      if (e == 5) begin
        n_cmp++; if (sw4 !== 1'b0) begin n_err++; $display("FAIL switch_early edge=%0d got %b want 0", e, sw4); end
      end
      if (e == 6 || e == 15) begin
        n_cmp++; if (sw4 !== 1'b1) begin n_err++; $display("FAIL switch_pending edge=%0d got %b want 1", e, sw4); end
      end
      if (e == 15) begin
        n_cmp++; if (mode4 !== 2'd0) begin n_err++; $display("FAIL switch_oldmode edge=%0d got %0d want 0", e, mode4); end
        n_cmp++; if (y4 !== 1'b1)    begin n_err++; $display("FAIL switch_high edge=%0d got %b want 1", e, y4); end
      end
      if (e == 16) begin
        n_cmp++; if (mode4 !== 2'd3) begin n_err++; $display("FAIL switch_newmode edge=%0d got %0d want 3", e, mode4); end
        n_cmp++; if (y4 !== 1'b0)    begin n_err++; $display("FAIL switch_fall edge=%0d got %b want 0", e, y4); end
        n_cmp++; if (sw4 !== 1'b0)   begin n_err++; $display("FAIL switch_clear edge=%0d got %b want 0", e, sw4); end
      end
      if (e > 16) begin
        n_cmp++; if (y4 !== 1'((e - 16) % 2))    begin n_err++; $display("FAIL switch_fast_y edge=%0d got %b want %b", e, y4, 1'((e - 16) % 2)); end
        n_cmp++; if (tick4 !== 1'((e - 16) % 2)) begin n_err++; $display("FAIL switch_fast_tick edge=%0d got %b want %b", e, tick4, 1'((e - 16) % 2)); end
      end
    end
  endtask

  task automatic test_cancel();
    start(2'd0);
    for (int e = 1; e <= 24; e++) begin
      step();
      if (e == 2) sel = 2'd1;
      if (e == 5) begin
        sel = 2'd0;
        n_cmp++; if (sw4 !== 1'b1) begin n_err++; $display("FAIL cancel_pending edge=%0d got %b want 1", e, sw4); end
      end
      if (e == 8) begin
        n_cmp++; if (sw4 !== 1'b0) begin n_err++; $display("FAIL cancel_drop edge=%0d got %b want 0", e, sw4); end
      end
      if (e >= 16) begin
        n_cmp++; if (mode4 !== 2'd0) begin n_err++; $display("FAIL cancel_mode edge=%0d got %0d want 0", e, mode4); end
        n_cmp++; if (y4 !== 1'((e / 8) % 2)) begin n_err++; $display("FAIL cancel_y edge=%0d got %b want %b", e, y4, 1'((e / 8) % 2)); end
      end
    end
  endtask

  task automatic test_invalid();
    start(2'd3);
    for (int e = 1; e <= 40; e++) begin
      step();
      n_cmp++; if (sw3 !== 1'b0)   begin n_err++; $display("FAIL invalid_switching edge=%0d got %b want 0", e, sw3); end
      n_cmp++; if (mode3 !== 2'd0) begin n_err++; $display("FAIL invalid_mode edge=%0d got %0d want 0", e, mode3); end
      n_cmp++; if (y3 !== 1'((e / 8) % 2)) begin n_err++; $display("FAIL invalid_y edge=%0d got %b want %b", e, y3, 1'((e / 8) % 2)); end
    end
  endtask

  task automatic test_async_reset();
    start(2'd0);
    for (int e = 1; e <= 8; e++) step();
    n_cmp++; if (tick4 !== 1'b1) begin n_err++; $display("FAIL areset_pretick got %b want 1", tick4); end
    step(); step();
    n_cmp++; if (y4 !== 1'b1) begin n_err++; $display("FAIL areset_prehigh got %b want 1", y4); end
    #2 reset = 1'b0;
    model_reset();
    #1;
    n_cmp++; if (y4 !== 1'b0)    begin n_err++; $display("FAIL areset_y got %b want 0", y4); end
    n_cmp++; if (tick4 !== 1'b0) begin n_err++; $display("FAIL areset_tick got %b want 0", tick4); end
    step(); step();
    reset = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      step();
      n_cmp++; if (y4 !== 1'(e >= 8))    begin n_err++; $display("FAIL areset_rise edge=%0d got %b want %b", e, y4, 1'(e >= 8)); end
      n_cmp++; if (tick4 !== 1'(e == 8)) begin n_err++; $display("FAIL areset_tick1 edge=%0d got %b want %b", e, tick4, 1'(e == 8)); end
    end
  endtask

  task automatic test_enable();
    start(2'd0);
    for (int e = 1; e <= 4; e++) step();
    en  = 1'b0;
    sel = 2'd1;
    for (int e = 5; e <= 10; e++) begin
      step();
      n_cmp++; if (y4 !== 1'b0)    begin n_err++; $display("FAIL enable_low_y edge=%0d got %b want 0", e, y4); end
      n_cmp++; if (tick4 !== 1'b0) begin n_err++; $display("FAIL enable_low_tick edge=%0d got %b want 0", e, tick4); end
      if (e == 7) begin
        n_cmp++; if (sw4 !== 1'b1)   begin n_err++; $display("FAIL enable_pending edge=%0d got %b want 1", e, sw4); end
        n_cmp++; if (mode4 !== 2'd0) begin n_err++; $display("FAIL enable_oldmode edge=%0d got %0d want 0", e, mode4); end
      end
      if (e == 8) begin
        n_cmp++; if (mode4 !== 2'd1) begin n_err++; $display("FAIL enable_apply edge=%0d got %0d want 1", e, mode4); end
        n_cmp++; if (sw4 !== 1'b0)   begin n_err++; $display("FAIL enable_clear edge=%0d got %b want 0", e, sw4); end
      end
    end
    en = 1'b1;
    for (int f = 1; f <= 20; f++) begin
      step();
      n_cmp++; if (y4 !== 1'((f / 4) % 2))    begin n_err++; $display("FAIL enable_y edge=%0d got %b want %b", f, y4, 1'((f / 4) % 2)); end
      n_cmp++; if (tick4 !== 1'(f % 8 == 4)) begin n_err++; $display("FAIL enable_tick edge=%0d got %b want %b", f, tick4, 1'(f % 8 == 4)); end
    end
  endtask

  task automatic test_random();
    start(2'd0);
    for (int i = 0; i < 3000; i++) begin
      step();
      n_cmp++; if (y4 !== m_y)            begin n_err++; $display("FAIL rand_y cyc=%0d got %b want %b", i, y4, m_y); end
      n_cmp++; if (tick4 !== m_tick)      begin n_err++; $display("FAIL rand_tick cyc=%0d got %b want %b", i, tick4, m_tick); end
      n_cmp++; if (mode4 !== 2'(m_mode))  begin n_err++; $display("FAIL rand_mode cyc=%0d got %0d want %0d", i, mode4, m_mode); end
      n_cmp++; if (sw4 !== m_sw)          begin n_err++; $display("FAIL rand_switching cyc=%0d got %b want %b", i, sw4, m_sw); end
      if ($urandom_range(0, 24) == 0) sel = 2'($urandom_range(0, 3));
      if (en && $urandom_range(0, 99) == 0) en = 1'b0;
      else if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
      if ($urandom_range(0, 599) == 0) begin
        #2 reset = 1'b0;
        model_reset();
        #1;
        n_cmp++; if ({y4, tick4, mode4, sw4} !== 5'b0) begin n_err++; $display("FAIL rand_reset cyc=%0d got %b want 00000", i, {y4, tick4, mode4, sw4}); end
        step();
        reset = 1'b1;
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    en    = 1'b0;
    sel   = 2'd0;
    test_reset();
    test_basic();
    test_switch();
    test_cancel();
    test_invalid();
    test_async_reset();
    test_enable();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL timeout reached at %0t, compared=%0d", $time, n_cmp);
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire
